// File: rtl/instruction_issue.sv
// Instruction issue stage: buffers 16-bit instructions in a small FIFO and hands them one at a
// time to the datapath control FSM via the s/w handshake, holding each in the IR until done.
module instruction_issue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [15:0]   in_instr,
    output logic          in_ready,
    input  logic          w,
    input  logic [2:0]    nsel,
    output logic          s,
    output logic [2:0]    opcode,
    output logic [1:0]    op,
    output logic [1:0]    ALUop,
    output logic [1:0]    shift,
    output logic [15:0]   sximm5,
    output logic [15:0]   sximm8,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic [AW:0]   count,
    output logic          illegal
);

    localparam logic [AW:0]   Full   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PtrOne = AW'(1);

    typedef enum logic [1:0] {StIdle, StIssue, StExec} state_e;

    state_e        state_q, state_d;
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   ir_q;
    logic          illegal_q;

    logic          push, pop;
    logic [15:0]   head;
    logic          head_legal;
    logic          load_ir;
    logic          drop_head;

    assign in_ready = (count_q != Full);
    // Full refuses pushes even when a pop happens in the same cycle.
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        head_legal = 1'b0;
        unique case (head[15:11])
            5'b110_10, 5'b110_00,
            5'b101_00, 5'b101_01, 5'b101_10, 5'b101_11: head_legal = 1'b1;
            default:                                   head_legal = 1'b0;
        endcase
    end

    assign load_ir   = pop && head_legal;
    assign drop_head = pop && !head_legal;

    // FIFO storage; contents need no reset since pointers and count gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_instr;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            count_q <= count_d;
        end
    end

    // Issue FSM: state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load_ir) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StExec;
            end
            StExec: begin
                if (w) begin
                    state_d = load_ir ? StIssue : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Issue FSM: outputs.
    always_comb begin
        s   = 1'b0;
        pop = 1'b0;
        unique case (state_q)
            StIdle:  pop = w && (count_q != '0);
            StIssue: s   = 1'b1;
            StExec:  pop = w && (count_q != '0);
            default: begin
                s   = 1'b0;
                pop = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q      <= 16'h0000;
            illegal_q <= 1'b0;
        end else begin
            if (load_ir) begin
                ir_q <= head;
            end
            if (drop_head) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign illegal = illegal_q;
    assign count   = count_q;

    // Decoded fields depend only on the IR, so they hold steady for the whole execution.
    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign ALUop  = ir_q[12:11];
    assign shift  = ir_q[4:3];
    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

    always_comb begin
        readnum = 3'b000;
        unique case (nsel)
            3'b100:  readnum = ir_q[10:8];
            3'b010:  readnum = ir_q[7:5];
            3'b001:  readnum = ir_q[2:0];
            default: readnum = 3'b000;
        endcase
    end

    assign writenum = readnum;

endmodule
